// File: rtl/serdes_tx_pkg.sv
// Shared definitions for the serdes2axi4stream write path: FSM encoding,
// statistics counter width and default packet length limit.
package serdes_tx_pkg;

  localparam int CNT_W               = 16;
  localparam int DEFAULT_MAX_PKT_LEN = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_ABORT  = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_GAP    = 3'd5
  } wr_state_e;

endpackage

// File: rtl/pkt_stall_watchdog.sv
// Counts consecutive stalled cycles and flags the cycle on which the count
// reaches C_TIMEOUT. Any non-stalled cycle clears the count.
module pkt_stall_watchdog #(
  parameter int C_TIMEOUT = 1024,
  parameter int CW        = $clog2(C_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall_i,
  output logic expire_o
);

  localparam logic [CW-1:0] TERM = CW'(C_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // advance while stalled, otherwise restart from zero
  always_comb begin
    cnt_d = '0;
    if (stall_i) cnt_d = cnt_q + CW'(1);
  end

  // expire on the stall cycle that brings the count to C_TIMEOUT
  assign expire_o = stall_i && (cnt_q == TERM);

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/axis_return_fifo_writer.sv
// AXI4-Stream packet writer for a commit/rollback FIFO. Every good beat is
// written straight into the FIFO; a clean TLAST pulses commit, an errored or
// overlength beat pulses rollback (then drains the rest of the packet).
// Optional stall watchdog: define PKT_WR_TIMEOUT_EN.
module axis_return_fifo_writer
  import serdes_tx_pkg::*;
#(
  parameter int C_DATA_WIDTH  = 32,
  parameter int C_MAX_PKT_LEN = DEFAULT_MAX_PKT_LEN,
  parameter int C_LEN_WIDTH   = $clog2(C_MAX_PKT_LEN + 1),
  parameter int C_TIMEOUT     = 1024
) (
  input  logic                    CLK_I,
  input  logic                    RSTN_I,
  input  logic                    S_AXIS_TVALID_I,
  output logic                    S_AXIS_TREADY_O,
  input  logic [C_DATA_WIDTH-1:0] S_AXIS_TDATA_I,
  input  logic                    S_AXIS_TLAST_I,
  input  logic                    S_AXIS_TUSER_I,
  output logic                    FIFO_WR_EN_O,
  output logic [C_DATA_WIDTH-1:0] FIFO_WR_DATA_O,
  input  logic                    FIFO_WR_FULL_I,
  output logic                    FIFO_WR_SUCC_O,
  output logic                    FIFO_WR_FAIL_O,
  output logic [CNT_W-1:0]        PKT_OK_CNT_O,
  output logic [CNT_W-1:0]        PKT_DROP_CNT_O,
  output logic [C_LEN_WIDTH-1:0]  PKT_LEN_O
);

  localparam logic [C_LEN_WIDTH-1:0] MAX_LEN = C_LEN_WIDTH'(C_MAX_PKT_LEN);

  wr_state_e              state_q, state_d;
  logic [C_LEN_WIDTH-1:0] len_q, len_d;
  logic [C_LEN_WIDTH-1:0] plen_q, plen_d;
  logic [CNT_W-1:0]       ok_q, ok_d;
  logic [CNT_W-1:0]       drop_q, drop_d;
  logic                   pend_q, pend_d;

  logic tready, wr_en, succ, fail, accept, wd_expire;

  assign accept = S_AXIS_TVALID_I && tready;

`ifdef PKT_WR_TIMEOUT_EN
  logic wd_stall;
  assign wd_stall = (state_q == ST_DATA) && S_AXIS_TVALID_I && FIFO_WR_FULL_I;

  pkt_stall_watchdog #(
    .C_TIMEOUT (C_TIMEOUT)
  ) u_wd (
    .clk      (CLK_I),
    .rst_n    (RSTN_I),
    .stall_i  (wd_stall),
    .expire_o (wd_expire)
  );
`else
  // no watchdog: a full FIFO back-pressures the stream indefinitely
  logic wd_unused;
  assign wd_unused = (C_TIMEOUT != 0);
  assign wd_expire = 1'b0;
`endif

  // next-state, handshake and strobe decode
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    plen_d  = plen_q;
    ok_d    = ok_q;
    drop_d  = drop_q;
    pend_d  = pend_q;
    tready  = 1'b0;
    wr_en   = 1'b0;
    succ    = 1'b0;
    fail    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        len_d = '0;
        if (S_AXIS_TVALID_I) state_d = ST_DATA;
      end
      ST_DATA: begin
        tready = ~FIFO_WR_FULL_I;
        if (accept) begin
          // errored or beyond the length limit: drop beat, roll back
          if (S_AXIS_TUSER_I || (len_q == MAX_LEN)) begin
            state_d = ST_ABORT;
            pend_d  = ~S_AXIS_TLAST_I;
          end else begin
            wr_en = 1'b1;
            len_d = len_q + C_LEN_WIDTH'(1);
            if (S_AXIS_TLAST_I) state_d = ST_COMMIT;
          end
        end else if (wd_expire) begin
          state_d = ST_ABORT;
          pend_d  = 1'b1;
        end
      end
      ST_COMMIT: begin
        succ    = 1'b1;
        ok_d    = ok_q + CNT_W'(1);
        plen_d  = len_q;
        state_d = ST_GAP;
      end
      ST_ABORT: begin
        fail    = 1'b1;
        drop_d  = drop_q + CNT_W'(1);
        state_d = pend_q ? ST_DRAIN : ST_GAP;
      end
      ST_DRAIN: begin
        tready = 1'b1;
        if (S_AXIS_TVALID_I && S_AXIS_TLAST_I) state_d = ST_IDLE;
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state and statistics registers
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      plen_q  <= '0;
      ok_q    <= '0;
      drop_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      plen_q  <= plen_d;
      ok_q    <= ok_d;
      drop_q  <= drop_d;
      pend_q  <= pend_d;
    end
  end

  assign S_AXIS_TREADY_O = tready;
  assign FIFO_WR_EN_O    = wr_en;
  assign FIFO_WR_DATA_O  = S_AXIS_TDATA_I;
  assign FIFO_WR_SUCC_O  = succ;
  assign FIFO_WR_FAIL_O  = fail;
  assign PKT_OK_CNT_O    = ok_q;
  assign PKT_DROP_CNT_O  = drop_q;
  assign PKT_LEN_O       = plen_q;

endmodule
